// File: rtl/memory_arbiter.sv
// Shares one external memory port between the fetch, read and write pipeline stages.
// One transaction in flight at a time; fixed priority write > read > fetch with fetch anti-starvation.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_address_enable,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_data_valid,
  input  logic        read_address_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  input  logic        write_address_enable,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  output logic        write_data_valid,
  output logic        mem_request,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [1:0]  GrantNone  = 2'd0;
  localparam logic [1:0]  GrantFetch = 2'd1;
  localparam logic [1:0]  GrantRead  = 2'd2;
  localparam logic [1:0]  GrantWrite = 2'd3;
  localparam logic [7:0]  StarveMax  = 8'(STARVE_LIMIT);
  localparam logic [7:0]  TimeoutMax = 8'(TIMEOUT_CYCLES);
  localparam logic [31:0] ErrData    = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  timeout_q, timeout_d;
  logic [7:0]  starve_q, starve_d;
  logic        err_q, err_d;
  logic [31:0] fetch_data_q, fetch_data_d;
  logic [31:0] read_data_q, read_data_d;

  logic        any_req;
  logic [1:0]  pick;
  logic        finish;
  logic [31:0] result;

  assign any_req = fetch_address_enable | read_address_enable | write_address_enable;

  always_comb begin
    pick = GrantNone;
    if (fetch_address_enable && (starve_q >= StarveMax)) begin
      pick = GrantFetch;
    end else if (write_address_enable) begin
      pick = GrantWrite;
    end else if (read_address_enable) begin
      pick = GrantRead;
    end else if (fetch_address_enable) begin
      pick = GrantFetch;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    timeout_d    = timeout_q;
    starve_d     = starve_q;
    err_d        = err_q;
    fetch_data_d = fetch_data_q;
    read_data_d  = read_data_q;
    finish       = 1'b0;
    result       = mem_read_data;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StAccess;
          owner_d   = pick;
          we_d      = (pick == GrantWrite);
          wdata_d   = (pick == GrantWrite) ? write_data : '0;
          timeout_d = '0;
          err_d     = 1'b0;
          unique case (pick)
            GrantWrite: addr_d = write_address;
            GrantRead:  addr_d = read_address;
            default:    addr_d = fetch_address;
          endcase
          if (pick == GrantFetch) begin
            starve_d = '0;
          end else if (fetch_address_enable && (starve_q < StarveMax)) begin
            starve_d = starve_q + 8'd1;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          finish = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (timeout_q == TimeoutMax)) begin
          finish = 1'b1;
          err_d  = 1'b1;
          result = ErrData;
        end else if (timeout_q != 8'hFF) begin
          timeout_d = timeout_q + 8'd1;
        end
        if (finish) begin
          state_d = StDone;
          // Stores have no return path; only loads/fetches capture a result.
          if (!we_q && (owner_q == GrantFetch)) fetch_data_d = result;
          if (!we_q && (owner_q == GrantRead))  read_data_d  = result;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= GrantNone;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      timeout_q    <= '0;
      starve_q     <= '0;
      err_q        <= 1'b0;
      fetch_data_q <= '0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      timeout_q    <= timeout_d;
      starve_q     <= starve_d;
      err_q        <= err_d;
      fetch_data_q <= fetch_data_d;
      read_data_q  <= read_data_d;
    end
  end

  logic in_access;
  logic in_done;

  always_comb begin
    in_access        = (state_q == StAccess);
    in_done          = (state_q == StDone);
    mem_request      = in_access;
    mem_write_enable = in_access & we_q;
    mem_address      = in_access ? addr_q : '0;
    mem_write_data   = (in_access && we_q) ? wdata_q : '0;
    fetch_data_valid = in_done && (owner_q == GrantFetch);
    read_data_valid  = in_done && (owner_q == GrantRead);
    write_data_valid = in_done && (owner_q == GrantWrite);
    bus_error        = in_done & err_q;
    grant            = (state_q == StIdle) ? GrantNone : owner_q;
    fetch_data       = fetch_data_q;
    read_data        = read_data_q;
  end

endmodule
